// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU frame sequencer.
// Holds the FSM state type, the default frame header bytes, the response status
// codes and a saturating increment used by the error counter.
package uart_alu_pkg;

   localparam logic [7:0] HDR_CMD_DEF = 8'hA5;   // command frame header
   localparam logic [7:0] HDR_RSP_DEF = 8'h5A;   // response frame header

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_BADCHK  = 8'h01;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_GET_OP    = 4'd1,
      S_GET_A     = 4'd2,
      S_GET_B     = 4'd3,
      S_GET_CHK   = 4'd4,
      S_EXEC      = 4'd5,
      S_SEND_HDR  = 4'd6,
      S_SEND_STAT = 4'd7,
      S_SEND_RES  = 4'd8
   } state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// FIFO-side bus of the sequencer: RX FIFO head/pop and TX FIFO push/full.
//   master : sequencer side (pops RX, pushes TX)
//   slave  : FIFO side
interface uart_alu_sequencer_if #(
   parameter int unsigned DBIT = 8
);
   logic [DBIT-1:0] r_data;     // RX head word, first-word-fall-through
   logic            rx_empty;
   logic            rd_uart;    // one-cycle RX pop
   logic            tx_full;
   logic [DBIT-1:0] w_data;     // TX push data
   logic            wr_uart;    // one-cycle TX push

   modport master (input r_data, rx_empty, tx_full, output rd_uart, w_data, wr_uart);
   modport slave  (output r_data, rx_empty, tx_full, input rd_uart, w_data, wr_uart);
endinterface

// File: rtl/frame_timeout_counter.sv
// Inter-byte timeout counter.
//   clk, reset  : clock, synchronous active-low reset
//   clr         : restart the count (a byte was popped)
//   en          : count this cycle (waiting for a byte)
//   expire      : one-cycle pulse on the TIMEOUT_CYC-th consecutive enabled cycle
module frame_timeout_counter
   import uart_alu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CW-1:0] cnt;

   // cnt holds the number of enabled cycles already elapsed, so the pulse
   // lands on the cycle that completes TIMEOUT_CYC of them.
   assign expire = en && !clr && (cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!reset)
         cnt <= '0;
      else if (clr || expire)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/uart_alu_sequencer.sv
// Frame-level controller between the UART FIFOs and an ALU.
// Pops a 5-byte command frame (HDR_CMD op A B chk), verifies the XOR checksum,
// drives the ALU and pushes a 3-byte response (HDR_RSP status result).
//   clk, reset  : clock, synchronous active-low reset
//   fifo        : RX/TX FIFO bus (master side)
//   alu_a/b/op  : ALU operands and opcode, held after a frame ends
//   alu_result  : combinational ALU result
//   busy        : high whenever not idle
//   err_cnt     : saturating count of checksum errors and inter-byte timeouts
module uart_alu_sequencer
   import uart_alu_pkg::*;
#(
   parameter int unsigned     DBIT        = 8,
   parameter int unsigned     N           = 7,
   parameter logic [DBIT-1:0] HDR_CMD     = HDR_CMD_DEF,
   parameter logic [DBIT-1:0] HDR_RSP     = HDR_RSP_DEF,
   parameter int unsigned     TIMEOUT_CYC = 1000000
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_alu_sequencer_if.master fifo,
   output logic [N:0]           alu_a,
   output logic [N:0]           alu_b,
   output logic [DBIT-1:0]      alu_op,
   input  logic [N:0]           alu_result,
   output logic                 busy,
   output logic [7:0]           err_cnt
);
   state_t          state, state_nxt;
   logic [N:0]      a_q;
   logic [N:0]      res_q;
   logic [DBIT-1:0] chk_q;
   logic [DBIT-1:0] status_q;
   logic            pop, push, tmo_en, expire;

   frame_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk    (clk),
      .reset  (reset),
      .clr    (pop),
      .en     (tmo_en),
      .expire (expire)
   );

   assign busy = (state != S_IDLE);

   always_comb begin
      state_nxt    = state;
      pop          = 1'b0;
      push         = 1'b0;
      tmo_en       = 1'b0;
      fifo.w_data  = '0;
      case (state)
         S_IDLE: begin
            if (!fifo.rx_empty) begin
               pop = 1'b1;
               if (fifo.r_data == HDR_CMD)
                  state_nxt = S_GET_OP;
            end
         end
         S_GET_OP, S_GET_A, S_GET_B, S_GET_CHK: begin
            tmo_en = fifo.rx_empty;
            if (!fifo.rx_empty) begin
               pop = 1'b1;
               case (state)
                  S_GET_OP: state_nxt = S_GET_A;
                  S_GET_A:  state_nxt = S_GET_B;
                  S_GET_B:  state_nxt = S_GET_CHK;
                  default:  state_nxt = (fifo.r_data == chk_q) ? S_EXEC : S_SEND_HDR;
               endcase
            end else if (expire) begin
               state_nxt = S_IDLE;
            end
         end
         S_EXEC: state_nxt = S_SEND_HDR;
         S_SEND_HDR: begin
            fifo.w_data = HDR_RSP;
            if (!fifo.tx_full) begin
               push      = 1'b1;
               state_nxt = S_SEND_STAT;
            end
         end
         S_SEND_STAT: begin
            fifo.w_data = status_q;
            if (!fifo.tx_full) begin
               push      = 1'b1;
               state_nxt = S_SEND_RES;
            end
         end
         S_SEND_RES: begin
            fifo.w_data = DBIT'(res_q);
            if (!fifo.tx_full) begin
               push      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // Strobes are suppressed while reset is held so no byte is lost or sent.
      fifo.rd_uart = pop & reset;
      fifo.wr_uart = push & reset;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         a_q      <= '0;
         res_q    <= '0;
         chk_q    <= '0;
         status_q <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_op   <= '0;
         err_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            case (state)
               S_IDLE: chk_q <= fifo.r_data;
               S_GET_OP: begin
                  alu_op <= fifo.r_data;
                  chk_q  <= chk_q ^ fifo.r_data;
               end
               S_GET_A: begin
                  a_q   <= fifo.r_data[N:0];
                  chk_q <= chk_q ^ fifo.r_data;
               end
               S_GET_B: begin
                  // Both operands change together so the ALU never sees a mixed pair.
                  alu_a <= a_q;
                  alu_b <= fifo.r_data[N:0];
                  chk_q <= chk_q ^ fifo.r_data;
               end
               S_GET_CHK: begin
                  if (fifo.r_data != chk_q) begin
                     status_q <= DBIT'(ST_BADCHK);
                     res_q    <= '0;
                     err_cnt  <= sat_inc8(err_cnt);
                  end
               end
               default: ;
            endcase
         end
         if (state == S_EXEC) begin
            res_q    <= alu_result;
            status_q <= DBIT'(ST_OK);
         end
         if (expire)
            err_cnt <= sat_inc8(err_cnt);
      end
   end
endmodule

// File: tb/tb_uart_alu_sequencer.sv
module tb_uart_alu_sequencer;
   localparam int TMO = 20;

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] alu_a, alu_b, alu_op, alu_result, err_cnt;
   logic       busy;

   uart_alu_sequencer_if #(.DBIT(8)) fifo_if ();

   uart_alu_sequencer #(
      .DBIT(8), .N(7), .HDR_CMD(8'hA5), .HDR_RSP(8'h5A), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .reset(reset), .fifo(fifo_if),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_ref(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         8'h01:   return a + b;
         8'h02:   return a - b;
         8'h03:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   always_comb alu_result = alu_ref(alu_op, alu_a, alu_b);

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- FIFO models ----------------
   logic [7:0] rx_q[$];
   logic [7:0] tx_got[$];
   logic       pend_rd = 1'b0, pend_wr = 1'b0;
   logic [7:0] pend_w = '0;
   int         viol = 0;
   int         gap_pct = 0, stall_pct = 0, hold_run = 0;
   logic       force_full = 1'b0;

   initial begin
      fifo_if.r_data   = '0;
      fifo_if.rx_empty = 1'b1;
      fifo_if.tx_full  = 1'b0;
   end

   always @(negedge clk) begin
      pend_rd = fifo_if.rd_uart;
      pend_wr = fifo_if.wr_uart;
      pend_w  = fifo_if.w_data;
      if (fifo_if.rd_uart && fifo_if.rx_empty) viol++;
      if (fifo_if.wr_uart && fifo_if.tx_full)  viol++;
   end

   always @(posedge clk) begin
      logic hold;
      #1;
      if (pend_rd && rx_q.size() != 0) void'(rx_q.pop_front());
      if (pend_wr) tx_got.push_back(pend_w);
      pend_rd = 1'b0;
      pend_wr = 1'b0;
      if (gap_pct != 0 && hold_run < 4 && $urandom_range(99) < gap_pct) begin
         hold = 1'b1;
         hold_run++;
      end else begin
         hold = 1'b0;
         hold_run = 0;
      end
      fifo_if.rx_empty = hold || (rx_q.size() == 0);
      fifo_if.r_data   = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      fifo_if.tx_full  = force_full || (stall_pct != 0 && $urandom_range(99) < stall_pct);
   end

   // ---------------- frame-level reference model ----------------
   logic [7:0] exp_a = '0, exp_b = '0, exp_op = '0, exp_err = '0;
   logic [7:0] exp_tx[$];

   task automatic model_stream(input byte_q_t s);
      int i = 0;
      logic [7:0] op, a, b, c;
      while (i < s.size()) begin
         if (s[i] != 8'hA5) begin
            i++;
            continue;
         end
         op = s[i+1]; a = s[i+2]; b = s[i+3]; c = s[i+4];
         i += 5;
         exp_op = op; exp_a = a; exp_b = b;
         if (c == (8'hA5 ^ op ^ a ^ b)) begin
            exp_tx.push_back(8'h5A); exp_tx.push_back(8'h00); exp_tx.push_back(alu_ref(op, a, b));
         end else begin
            exp_tx.push_back(8'h5A); exp_tx.push_back(8'h01); exp_tx.push_back(8'h00);
            if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
         end
      end
   endtask

   task automatic start_stream(input byte_q_t s);
      exp_tx.delete();
      tx_got.delete();
      model_stream(s);
      foreach (s[i]) rx_q.push_back(s[i]);
   endtask

   task automatic finish_stream(input string tag, input int budget);
      int k;
      int nbad = 0;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (rx_q.size() == 0 && !busy) break;
      end
      check_eq({tag, "_drained"}, (k < budget), 1);
      repeat (2) @(negedge clk);
      check_eq({tag, "_tx_len"}, tx_got.size(), exp_tx.size());
      foreach (exp_tx[i])
         if (i >= tx_got.size() || tx_got[i] !== exp_tx[i]) begin
            if (nbad == 0)
               $display("  %s first bad tx byte %0d: got %0h want %0h", tag, i,
                        (i < tx_got.size()) ? tx_got[i] : 8'hxx, exp_tx[i]);
            nbad++;
         end
      check_eq({tag, "_tx_bytes_bad"}, nbad, 0);
      check_eq({tag, "_err_cnt"}, err_cnt, exp_err);
      check_eq({tag, "_alu_a"}, alu_a, exp_a);
      check_eq({tag, "_alu_b"}, alu_b, exp_b);
      check_eq({tag, "_alu_op"}, alu_op, exp_op);
   endtask

   task automatic run_stream(input string tag, input byte_q_t s, input int budget);
      start_stream(s);
      finish_stream(tag, budget);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_err"}, err_cnt, 0);
      check_eq({tag, "_alu"}, {alu_a, alu_b, alu_op}, 0);
      check_eq({tag, "_strobes"}, {fifo_if.rd_uart, fifo_if.wr_uart}, 0);
      check_eq({tag, "_w_data"}, fifo_if.w_data, 0);
   endtask

   function automatic byte_q_t make_frame(input logic [7:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic good);
      byte_q_t f;
      logic [7:0] c;
      c = 8'hA5 ^ op ^ a ^ b;
      if (!good) c = c ^ 8'($urandom_range(1, 255));
      f = {8'hA5, op, a, b, c};
      return f;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      byte_q_t s;
      int k, bad;

      // reset state
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;

      // directed frames
      run_stream("valid", {8'hA5, 8'h01, 8'h03, 8'h04, 8'hA3}, 200);
      check_eq("valid_result", alu_result, 8'h07);
      run_stream("badchk", {8'hA5, 8'h01, 8'h03, 8'h04, 8'h00}, 200);
      run_stream("garbage", {8'h11, 8'h22, 8'hA5, 8'h03, 8'hF0, 8'h3C, 8'h6A}, 200);

      // timeout after the opcode byte
      tx_got.delete();
      rx_q.push_back(8'hA5);
      rx_q.push_back(8'h01);
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (fifo_if.rd_uart && fifo_if.r_data == 8'h01) break;
      end
      check_eq("tmo_op_popped", (k < 50), 1);
      repeat (TMO) @(negedge clk);
      check_eq("tmo_busy_before", busy, 1);
      @(negedge clk);
      check_eq("tmo_busy_after", busy, 0);
      exp_op = 8'h01;
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      check_eq("tmo_err", err_cnt, exp_err);
      check_eq("tmo_no_tx", tx_got.size(), 0);
      run_stream("after_tmo", make_frame(8'h02, 8'h10, 8'h07, 1'b1), 200);

      // TX full held during the status byte
      start_stream(make_frame(8'h02, 8'h09, 8'h03, 1'b1));
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (fifo_if.wr_uart && fifo_if.w_data == 8'h5A) break;
      end
      check_eq("stall_hdr_seen", (k < 200), 1);
      force_full = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (fifo_if.wr_uart !== 1'b0 || fifo_if.w_data !== 8'h00 || !busy || tx_got.size() != 1) bad++;
      end
      check_eq("stall_hold_bad", bad, 0);
      force_full = 1'b0;
      finish_stream("stall", 200);

      // randomized streams with RX gaps and TX back-pressure
      gap_pct = 25;
      stall_pct = 30;
      for (int it = 0; it < 30; it++) begin
         s.delete();
         for (int j = 0; j < $urandom_range(1, 4); j++) begin
            case ($urandom_range(0, 2))
               0: begin
                  logic [7:0] g;
                  do g = 8'($urandom_range(0, 255)); while (g == 8'hA5);
                  s.push_back(g);
               end
               default: begin
                  byte_q_t f;
                  f = make_frame(8'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
                                 ($urandom_range(0, 3) != 0));
                  foreach (f[m]) s.push_back(f[m]);
               end
            endcase
         end
         run_stream($sformatf("rnd%0d", it), s, 2000);
      end
      gap_pct = 0;
      stall_pct = 0;

      // err_cnt saturation
      s.delete();
      for (int j = 0; j < 260; j++) begin
         byte_q_t f;
         f = make_frame(8'h01, 8'($urandom), 8'($urandom), 1'b0);
         foreach (f[m]) s.push_back(f[m]);
      end
      run_stream("sat", s, 20000);
      check_eq("sat_ff", err_cnt, 8'hFF);

      // reset in the middle of a frame
      tx_got.delete();
      rx_q.push_back(8'hA5);
      rx_q.push_back(8'h01);
      rx_q.push_back(8'h03);
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (rx_q.size() == 0) break;
      end
      check_eq("midrst_busy", busy, 1);
      reset = 1'b0;
      @(negedge clk);
      check_zero("midrst");
      reset = 1'b1;
      exp_a = '0; exp_b = '0; exp_op = '0; exp_err = '0;
      s = {8'h04, 8'hA3};
      begin
         byte_q_t f;
         f = make_frame(8'h03, 8'hCC, 8'h0F, 1'b1);
         foreach (f[m]) s.push_back(f[m]);
      end
      run_stream("resync", s, 200);

      check_eq("proto_viol", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
